bus_cycle_sequencer: RTL and testbench

//  CPU-side bus cycle engine; consumes RDY from the ready generator.

---
 rtl/bus_cycle_sequencer_if.sv | 42 ++++
 rtl/bus_cycle_sequencer.sv | 161 ++++++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_cycle_sequencer_if.sv
// Core request/ack handshake and 8088-style bus pins for the bus cycle sequencer.
// master: the sequencer; slave: the core and bus environment that drive it.
interface bus_cycle_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_type;
    logic        req_write;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        ack;
    logic [7:0]  rdata;
    logic        timeout;
    logic        RDY;
    logic [7:0]  bus_din;
    logic        ALE;
    logic [19:0] ADDR;
    logic [7:0]  DOUT;
    logic        IO_OR_M;
    logic        DT_R_N;
    logic        DEN_N;
    logic        MEMR_N;
    logic        MEMW_N;
    logic        IOR_N;
    logic        IOW_N;
    logic        INTA_N;

    modport master (
        input  req_valid, req_type, req_write, req_addr, req_wdata,
        input  RDY, bus_din,
        output req_ready, ack, rdata, timeout,
        output ALE, ADDR, DOUT, IO_OR_M, DT_R_N, DEN_N,
        output MEMR_N, MEMW_N, IOR_N, IOW_N, INTA_N
    );

    modport slave (
        output req_valid, req_type, req_write, req_addr, req_wdata,
        output RDY, bus_din,
        input  req_ready, ack, rdata, timeout,
        input  ALE, ADDR, DOUT, IO_OR_M, DT_R_N, DEN_N,
        input  MEMR_N, MEMW_N, IOR_N, IOW_N, INTA_N
    );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// CPU-side bus cycle engine: runs T1/T2/T3/Tw/T4 cycles per core request,
// inserts wait states from RDY and forces completion after MAX_WAIT waits.
module bus_cycle_sequencer #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cpu_clock_posedge,
    input  logic                  cpu_clock_negedge,
    bus_cycle_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_TI, S_T1, S_T2, S_T3, S_TW, S_T4
    } state_t;

    localparam logic [1:0] TY_MEMR = 2'd0;
    localparam logic [1:0] TY_MEMW = 2'd1;
    localparam logic [1:0] TY_IO   = 2'd2;
    localparam logic [1:0] TY_INTA = 2'd3;
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  type_q;
    logic        write_q;
    logic [19:0] addr_q;
    logic [7:0]  dout_q;
    logic [7:0]  rdata_q;
    logic [7:0]  wait_cnt;
    logic        ale_done;
    logic        ack_q;
    logic        timeout_q;
    logic        io_or_m_q;
    logic        dt_r_n_q;
    logic        accept;
    logic        done_rdy;
    logic        done_forced;
    logic        cmd_phase;
    logic        req_is_write;
    logic [4:0]  strb;

    assign bus.req_ready = (state == S_TI) || (state == S_T4);
    assign accept = bus.req_valid & bus.req_ready & cpu_clock_posedge;
    assign req_is_write = (bus.req_type == TY_MEMW) ||
                          ((bus.req_type == TY_IO) && bus.req_write);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_TI;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        done_rdy    = 1'b0;
        done_forced = 1'b0;
        if (cpu_clock_posedge) begin
            unique case (state)
                S_TI: if (accept) state_nxt = S_T1;
                S_T1: state_nxt = S_T2;
                S_T2: state_nxt = S_T3;
                S_T3: begin
                    if (bus.RDY) begin
                        state_nxt = S_T4;
                        done_rdy  = 1'b1;
                    end else begin
                        state_nxt = S_TW;
                    end
                end
                S_TW: begin
                    // the wait limit wins over a late RDY
                    if (wait_cnt == WAIT_LIMIT) begin
                        state_nxt   = S_T4;
                        done_forced = 1'b1;
                    end else if (bus.RDY) begin
                        state_nxt = S_T4;
                        done_rdy  = 1'b1;
                    end else begin
                        state_nxt = S_TW;
                    end
                end
                S_T4: state_nxt = accept ? S_T1 : S_TI;
                default: state_nxt = S_TI;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            type_q    <= TY_MEMR;
            write_q   <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            rdata_q   <= 8'hFF;
            wait_cnt  <= '0;
            ale_done  <= 1'b1;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            io_or_m_q <= 1'b0;
            dt_r_n_q  <= 1'b1;
        end else begin
            ack_q <= done_rdy | done_forced;
            if (accept) begin
                type_q    <= bus.req_type;
                write_q   <= req_is_write;
                addr_q    <= bus.req_addr;
                io_or_m_q <= bus.req_type[1];
                dt_r_n_q  <= req_is_write;
                timeout_q <= 1'b0;
                wait_cnt  <= '0;
                ale_done  <= 1'b0;
                if (req_is_write) dout_q <= bus.req_wdata;
            end else if ((state == S_T1) && cpu_clock_negedge) begin
                ale_done <= 1'b1;
            end
            if (cpu_clock_posedge && (state_nxt == S_TW) &&
                (wait_cnt != 8'hFF)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (done_rdy && !write_q) rdata_q <= bus.bus_din;
            if (done_forced) begin
                timeout_q <= 1'b1;
                if (!write_q) rdata_q <= 8'hFF;
            end
        end
    end

    assign cmd_phase = (state == S_T2) || (state == S_T3) || (state == S_TW);

    // strb = {memr, memw, ior, iow, inta}, active-high
    always_comb begin
        strb = '0;
        if (cmd_phase) begin
            unique case (1'b1)
                type_q == TY_MEMR:              strb[4] = 1'b1;
                type_q == TY_MEMW:              strb[3] = 1'b1;
                (type_q == TY_IO) && !write_q:  strb[2] = 1'b1;
                (type_q == TY_IO) && write_q:   strb[1] = 1'b1;
                type_q == TY_INTA:              strb[0] = 1'b1;
                default:                        strb    = '0;
            endcase
        end
    end

    assign bus.MEMR_N  = ~strb[4];
    assign bus.MEMW_N  = ~strb[3];
    assign bus.IOR_N   = ~strb[2];
    assign bus.IOW_N   = ~strb[1];
    assign bus.INTA_N  = ~strb[0];
    assign bus.DEN_N   = ~cmd_phase;
    assign bus.ALE     = (state == S_T1) && !ale_done;
    assign bus.ADDR    = addr_q;
    assign bus.DOUT    = dout_q;
    assign bus.IO_OR_M = io_or_m_q;
    assign bus.DT_R_N  = dt_r_n_q;
    assign bus.ack     = ack_q;
    assign bus.rdata   = rdata_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Scoreboard bench for bus_cycle_sequencer: directed spec cycles plus
// randomized requests checked against a cycle-count reference model.
module tb_bus_cycle_sequencer;
    localparam int MW = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic cpu_clock_posedge = 1'b0;
    logic cpu_clock_negedge = 1'b0;

    bus_cycle_sequencer_if bus ();

    bus_cycle_sequencer #(.MAX_WAIT(MW)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .cpu_clock_posedge (cpu_clock_posedge),
        .cpu_clock_negedge (cpu_clock_negedge),
        .bus               (bus)
    );

    typedef struct {
        int          acc;
        int          waits;
        logic        forced;
        logic [1:0]  ty;
        logic        wr;
        logic [19:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         edge_id = 0;
    int         mon_edge = 0;
    int         phase = 3;
    bit         mon_en = 1'b0;
    bit         ale_seen = 1'b0;
    bit         stop_run = 1'b0;
    logic [7:0] model_rdata = 8'hFF;

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // cpu clock = 4 system clocks: rise pulse at phase 0, fall at phase 2
    task automatic tick();
        @(negedge clock);
        phase = (phase + 1) % 4;
        cpu_clock_posedge = (phase == 0);
        cpu_clock_negedge = (phase == 2);
        if (cpu_clock_posedge) edge_id++;
    endtask

    task automatic junk_req();
        bus.req_type  = 2'($urandom);
        bus.req_write = 1'($urandom);
        bus.req_addr  = 20'($urandom);
        bus.req_wdata = 8'($urandom);
    endtask

    task automatic check_cycle();
        logic [8:0] act_ctl;
        logic [8:0] exp_ctl;
        logic [4:0] exp_strb;
        int         k;
        bit         active;
        bit         at_end;
        act_ctl = {bus.ALE, bus.ack, bus.req_ready, bus.DEN_N,
                   bus.MEMR_N, bus.MEMW_N, bus.IOR_N, bus.IOW_N,
                   bus.INTA_N};
        if (sb.size() == 0) begin
            chk("idle_ctl", 32'(act_ctl), 32'(9'b001111111));
            return;
        end
        k = mon_edge - sb[0].acc;
        if (k == 0 && cpu_clock_posedge) ale_seen = 1'b0;
        if (cpu_clock_negedge) ale_seen = 1'b1;
        at_end = (k == 3 + sb[0].waits) && cpu_clock_posedge;
        active = (k >= 1) && (k < 3 + sb[0].waits);
        exp_strb = 5'b11111;
        if (active) begin
            case (sb[0].ty)
                2'd0:    exp_strb[4] = 1'b0;
                2'd1:    exp_strb[3] = 1'b0;
                2'd2:    if (sb[0].wr) exp_strb[1] = 1'b0;
                         else exp_strb[2] = 1'b0;
                default: exp_strb[0] = 1'b0;
            endcase
        end
        exp_ctl = {(k == 0) && !ale_seen, at_end, at_end, !active, exp_strb};
        chk("ctl", 32'(act_ctl), 32'(exp_ctl));
        chk("addr", 32'(bus.ADDR), 32'(sb[0].addr));
        chk("io_dtr", 32'({bus.IO_OR_M, bus.DT_R_N}),
            32'({sb[0].ty[1], sb[0].wr}));
        if (sb[0].wr) chk("dout", 32'(bus.DOUT), 32'(sb[0].wdata));
        chk("timeout", 32'(bus.timeout), 32'(at_end & sb[0].forced));
        if (at_end) begin
            chk("rdata", 32'(bus.rdata), 32'(sb[0].rdata));
            void'(sb.pop_front());
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (cpu_clock_posedge) mon_edge++;
        if (mon_en) check_cycle();
    end

    // n_low: number of RDY=0 samples in T3/Tw before RDY rises
    task automatic do_txn(input logic [1:0] ty, input logic wr,
                          input logic [19:0] addr, input logic [7:0] wdata,
                          input logic [7:0] din, input int n_low,
                          input int idle, input int abort_r);
        exp_t e;
        int   budget;
        int   r;
        if (stop_run) return;
        repeat (idle) begin
            tick();
            bus.req_valid = 1'b0;
            junk_req();
            bus.RDY = 1'($urandom);
        end
        bus.req_valid = 1'b1;
        bus.req_type  = ty;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.bus_din   = din;
        budget = 0;
        while (!(cpu_clock_posedge && bus.req_ready)) begin
            tick();
            bus.RDY = 1'($urandom);
            budget++;
            if (budget > 64) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_wait: got no req_ready expected within 64 clocks");
                stop_run = 1'b1;
                return;
            end
        end
        e.acc    = edge_id;
        e.forced = (n_low >= MW);
        e.waits  = e.forced ? MW : n_low;
        e.ty     = ty;
        e.wr     = (ty == 2'd1) || (ty == 2'd2 && wr);
        e.addr   = addr;
        e.wdata  = wdata;
        if (!e.wr) model_rdata = e.forced ? 8'hFF : din;
        e.rdata  = model_rdata;
        sb.push_back(e);
        forever begin
            tick();
            bus.req_valid = 1'($urandom);
            junk_req();
            if (cpu_clock_posedge) begin
                r = edge_id - e.acc;
                bus.RDY = (r >= 3) ? (r - 3 >= n_low) : 1'($urandom);
                if (r == 3 + e.waits || r == abort_r) begin
                    bus.req_valid = 1'b0;
                    break;
                end
            end
        end
        tick();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_type  = 2'd0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.RDY       = 1'b0;
        bus.bus_din   = '0;
        repeat (3) tick();
        #1;
        chk("rst_ctl", 32'({bus.ALE, bus.ack, bus.req_ready, bus.DEN_N,
            bus.MEMR_N, bus.MEMW_N, bus.IOR_N, bus.IOW_N, bus.INTA_N}),
            32'(9'b001111111));
        chk("rst_rdata", 32'(bus.rdata), 32'(8'hFF));
        chk("rst_misc", 32'({bus.timeout, bus.DT_R_N, bus.IO_OR_M}),
            32'(3'b010));
        chk("rst_addr", 32'(bus.ADDR), 32'd0);
        chk("rst_dout", 32'(bus.DOUT), 32'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        do_txn(2'd0, 1'b0, 20'h12345, 8'h00, 8'h5A, 0, 2, -1);
        do_txn(2'd2, 1'b1, 20'h000A0, 8'h3C, 8'hC3, 3, 3, -1);
        do_txn(2'd0, 1'b0, 20'h0F00F, 8'h00, 8'h77, 9, 2, -1);
        do_txn(2'd0, 1'b0, 20'h00111, 8'h00, 8'h11, 0, 1, -1);
        do_txn(2'd1, 1'b0, 20'hAAAAA, 8'h55, 8'h00, 1, 1, -1);
        do_txn(2'd1, 1'b0, 20'h55555, 8'hAA, 8'h00, 0, 0, -1);
        do_txn(2'd3, 1'b0, 20'h00000, 8'h00, 8'h08, 0, 2, -1);
        do_txn(2'd2, 1'b1, 20'h00300, 8'hE1, 8'h00, 4, 1, -1);

        for (int i = 0; i < 40; i++) begin
            do_txn(2'($urandom_range(0, 3)), 1'($urandom),
                   20'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 6)),
                   ($urandom_range(0, 1) == 0) ? 0
                       : int'($urandom_range(1, 5)), -1);
        end

        // io read aborted by reset while in the second wait state
        do_txn(2'd2, 1'b0, 20'h003F8, 8'h00, 8'h99, 3, 1, 4);
        if (!stop_run) begin
            #2;
            mon_en  = 1'b0;
            reset_n = 1'b0;
            #1;
            chk("abort_ctl", 32'({bus.ALE, bus.ack, bus.req_ready, bus.DEN_N,
                bus.MEMR_N, bus.MEMW_N, bus.IOR_N, bus.IOW_N, bus.INTA_N}),
                32'(9'b001111111));
            chk("abort_rdata", 32'(bus.rdata), 32'(8'hFF));
            chk("abort_timeout", 32'(bus.timeout), 32'd0);
            sb.delete();
            model_rdata = 8'hFF;
            repeat (4) tick();
            reset_n = 1'b1;
            mon_en  = 1'b1;
        end
        do_txn(2'd2, 1'b0, 20'h003F8, 8'h00, 8'h42, 1, 2, -1);
        for (int i = 0; i < 6; i++) begin
            do_txn(2'($urandom_range(0, 3)), 1'($urandom),
                   20'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 6)), int'($urandom_range(0, 2)), -1);
        end

        repeat (40) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
